mem_arb: RTL and testbench
==========================

# mem_arb

Single-port data memory arbiter and access sequencer. Shares one `ldst_mem` instance between the instruction-fetch requester and the load/store requester in the `mem` stage. Each access is held stable on the memory for `MEM_LATENCY` cycles, then the result is returned with a one-cycle valid pulse. Load/store has priority, and a starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- `MEM_LATENCY`, default 2: cycles the memory inputs are held per access. Legal range is 1 or more.
- `STARVE_LIMIT`, default 4: maximum consecutive load/store grants while fetch is waiting.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `if_req` in 1: fetch request. Held until `if_gnt`.
- `if_addr` in 16: fetch address.
- `if_gnt` out 1: fetch request accepted.
- `if_rvalid` out 1: fetch data valid (one-cycle pulse).
- `if_rdata` out 16: fetch read data.
- `ls_req` in 1: load/store request. Held until `ls_gnt`.
- `ls_addr` in 16: load/store address.
- `ls_wdata` in 16: store data.
- `ls_wr` in 1: 1 = store, 0 = load.
- `ls_gnt` out 1: load/store request accepted.
- `ls_rvalid` out 1: load data valid, or store complete (one-cycle pulse).
- `ls_rdata` out 16: load data. 0 for stores.
- `ls_err` out 1: memory error for this access. Valid with `ls_rvalid`.
- `mem_addr` out 16: address to `ldst_mem`.
- `mem_data_in` out 16: write data to `ldst_mem`.
- `mem_enable` out 1: access enable to `ldst_mem`.
- `mem_wr` out 1: write enable to `ldst_mem`.
- `mem_data_out` in 16: read data from `ldst_mem`.
- `mem_err` in 1: error from `ldst_mem`.
- `busy` out 1: arbiter not in IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: memory access in progress.
  - RESP: return data.
- IDLE, no request: stay in IDLE.
- IDLE, any request present: pick a winner and assert its `gnt` combinationally in the same cycle.
  - Latch owner, address, write data and `wr`.
  - Load the counter with `MEM_LATENCY-1` and go to BUSY.
- Winner selection:
  - If `starve_cnt == STARVE_LIMIT` and `if_req` is high, fetch wins.
  - Otherwise load/store wins whenever `ls_req` is high.
- `starve_cnt`:
  - +1 on each load/store grant while `if_req` is high.
  - Cleared on a fetch grant, or when `if_req` is low in IDLE.
  - Saturates at `STARVE_LIMIT`.
- BUSY:
  - `mem_enable` is 1. `mem_addr` and `mem_data_in` come from the latched registers.
  - `mem_wr` is 1 only for a latched store. Fetch never writes.
  - Counter decrements each cycle.
  - When the counter is 0: capture `mem_data_out` (forced to 0 on a store) and `mem_err`, then go to RESP.
- RESP:
  - Pulse the owner's `rvalid` for one cycle with the registered data. `ls_err` is driven only when the owner is load/store, else 0.
  - Go to IDLE.
- No grant is issued outside IDLE. Requests asserted during BUSY or RESP wait and must be held by the requester.
- Simultaneous `if_req` and `ls_req` with the starvation limit not reached: load/store is granted, fetch waits.
- Reset asserted mid-access: the access is abandoned, no `rvalid` is issued, and the memory write may be partial. Software tolerates this only at reset.

## Timing
- Reset values:
  - State IDLE, `starve_cnt` 0.
  - All outputs 0, including `busy`, both `gnt`s, both `rvalid`s, both `rdata`s, `ls_err` and all `mem_*` outputs.
- Request at cycle 0 (arbiter in IDLE):
  - Cycle 0: `gnt`.
  - Cycles 1..`MEM_LATENCY`: `mem_enable`.
  - Cycle `MEM_LATENCY+1`: `rvalid`.
  - Cycle `MEM_LATENCY+2`: arbiter back in IDLE and may grant again.
- Throughput: one access per `MEM_LATENCY+2` cycles.
- `gnt` depends combinationally on the `req` inputs. All other outputs are registered or depend on state only.
- `mem_*` outputs are 0 outside BUSY.
- Counter width is `$clog2(MEM_LATENCY+1)`. `starve_cnt` width is `$clog2(STARVE_LIMIT+1)`.

## Structure
- Package `mem_arb_pkg`:
  - `state_t` enum {IDLE, BUSY, RESP}.
  - `owner_t` enum {OWN_IF, OWN_LS}.
- Sub-module `mem_arb_pick`: combinational winner select plus the `starve_cnt` register.
- Top-level `mem_arb`: FSM, latency counter, address/data latches, response registers.

## Test plan
- Fetch only, `if_addr`=0x0040, `mem_data_out`=0xBEEF, `MEM_LATENCY`=2: `if_gnt` at cycle 0, `mem_enable` at cycles 1–2, `if_rvalid` with `if_rdata`=0xBEEF at cycle 3.
- Store at `ls_addr`=0x0100 with `ls_wdata`=0x1234: `mem_wr`=1 with `mem_addr`=0x0100 and `mem_data_in`=0x1234 during BUSY; `ls_rvalid` with `ls_rdata`=0 at cycle 3.
- `if_req` and `ls_req` both held continuously, `STARVE_LIMIT`=4: grant order is LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- `mem_err`=1 during a load: `ls_rvalid`=1 with `ls_err`=1; `ls_err` is 0 on the following fetch response.
- `rst` pulsed at cycle 1 of a load: all outputs are 0 immediately and no `ls_rvalid` is seen; a new `ls_req` after reset is granted in its first cycle.
- Back-to-back loads: the second `ls_gnt` arrives exactly `MEM_LATENCY+2` cycles after the first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb shared types: FSM states, access owner, bus widths.
// Imported by the arbiter, its picker and its bus interface.
package mem_arb_pkg;

  localparam int AW = 16;
  localparam int DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb bus: fetch port, load/store port, ldst_mem port, busy.
// slave = arbiter view, master = requesters + memory view.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_wr;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          ls_err;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic          mem_enable;
  logic          mem_wr;
  logic [DW-1:0] mem_data_out;
  logic          mem_err;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_addr, ls_wdata, ls_wr,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_addr, mem_data_in, mem_enable, mem_wr,
    input  mem_data_out, mem_err,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_addr, ls_wdata, ls_wr,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_addr, mem_data_in, mem_enable, mem_wr,
    output mem_data_out, mem_err,
    input  busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner select (load/store priority) with fetch starvation guard.
// Ports: clk, rst, i_idle, i_if_req, i_ls_req -> o_if_win, o_ls_win.
module mem_arb_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_idle,
  input  logic i_if_req,
  input  logic i_ls_req,
  output logic o_if_win,
  output logic o_ls_win
);
  import mem_arb_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;
  logic          w_lim;
  logic          w_if_pick;

  assign w_lim     = (r_starve == LIM);
  // fetch wins when starved or when load/store is not asking
  assign w_if_pick = i_if_req & (w_lim | ~i_ls_req);
  assign o_if_win  = i_idle & w_if_pick;
  assign o_ls_win  = i_idle & i_ls_req & ~w_if_pick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (i_idle) begin
      if (!i_if_req || o_if_win)
        r_starve <= '0;
      else if (o_ls_win && !w_lim)
        r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port ldst_mem arbiter: grant, hold access MEM_LATENCY cycles, respond.
// Ports: clk, rst (async, active-high), bus (mem_arb_if.slave).
module mem_arb #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_arb_if.slave bus
);
  import mem_arb_pkg::*;

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LD = CW'(MEM_LATENCY - 1);

  state_t        r_state;
  state_t        w_nxt;
  owner_t        r_own;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_wr;
  logic [DW-1:0] r_rdata;
  logic          r_err;

  logic w_idle;
  logic w_if_win;
  logic w_ls_win;
  logic w_gnt;
  logic w_in_busy;
  logic w_in_resp;
  logic w_cnt_done;

  assign w_idle     = (r_state == IDLE);
  assign w_in_busy  = (r_state == BUSY);
  assign w_in_resp  = (r_state == RESP);
  assign w_gnt      = w_if_win | w_ls_win;
  assign w_cnt_done = (r_cnt == '0);

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .i_idle  (w_idle),
    .i_if_req(bus.if_req),
    .i_ls_req(bus.ls_req),
    .o_if_win(w_if_win),
    .o_ls_win(w_ls_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt) w_nxt = BUSY;
      BUSY:    if (w_cnt_done) w_nxt = RESP;
      RESP:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own   <= OWN_IF;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_idle && w_gnt) begin
        r_own   <= w_ls_win ? OWN_LS : OWN_IF;
        r_addr  <= w_ls_win ? bus.ls_addr : bus.if_addr;
        r_wdata <= w_ls_win ? bus.ls_wdata : '0;
        r_wr    <= w_ls_win & bus.ls_wr;
        r_cnt   <= CNT_LD;
      end else if (w_in_busy) begin
        if (w_cnt_done) begin
          r_rdata <= r_wr ? '0 : bus.mem_data_out;
          r_err   <= bus.mem_err;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.if_gnt      = w_if_win;
  assign bus.ls_gnt      = w_ls_win;

  assign bus.mem_enable  = w_in_busy;
  assign bus.mem_wr      = w_in_busy & r_wr;
  assign bus.mem_addr    = w_in_busy ? r_addr : '0;
  assign bus.mem_data_in = w_in_busy ? r_wdata : '0;

  assign bus.if_rvalid   = w_in_resp & (r_own == OWN_IF);
  assign bus.ls_rvalid   = w_in_resp & (r_own == OWN_LS);
  assign bus.if_rdata    = bus.if_rvalid ? r_rdata : '0;
  assign bus.ls_rdata    = bus.ls_rvalid ? r_rdata : '0;
  assign bus.ls_err      = bus.ls_rvalid & r_err;

  assign bus.busy        = ~w_idle;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb (MEM_LATENCY=2, STARVE_LIMIT=4).
// Inputs change 1ns after posedge; outputs checked at negedge.
module tb_mem_arb;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  mem_arb_if bus();

  mem_arb #(
    .MEM_LATENCY (2),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    do begin
      tick();
      mid();
      k++;
    end while (bus.busy && k < 10);
    chk("drain_idle", 32'(bus.busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(bus.busy), 0);
    chk({tag, "_ifgnt"}, 32'(bus.if_gnt), 0);
    chk({tag, "_lsgnt"}, 32'(bus.ls_gnt), 0);
    chk({tag, "_ifrv"},  32'(bus.if_rvalid), 0);
    chk({tag, "_lsrv"},  32'(bus.ls_rvalid), 0);
    chk({tag, "_ifrd"},  32'(bus.if_rdata), 0);
    chk({tag, "_lsrd"},  32'(bus.ls_rdata), 0);
    chk({tag, "_lserr"}, 32'(bus.ls_err), 0);
    chk({tag, "_men"},   32'(bus.mem_enable), 0);
    chk({tag, "_mwr"},   32'(bus.mem_wr), 0);
    chk({tag, "_maddr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mdin"},  32'(bus.mem_data_in), 0);
  endtask

  logic [1:0] exp_ord [10];
  int         ng;
  int         cyc;
  logic       seen;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    bus.if_req = 0;
    bus.if_addr = '0;
    bus.ls_req = 0;
    bus.ls_addr = '0;
    bus.ls_wdata = '0;
    bus.ls_wr = 0;
    bus.mem_data_out = '0;
    bus.mem_err = 0;

    // reset state
    repeat (2) tick();
    mid();
    chk_all_zero("rst");
    tick();
    rst = 1'b0;

    // fetch only
    tick();
    bus.if_req = 1;
    bus.if_addr = 16'h0040;
    bus.mem_data_out = 16'hBEEF;
    mid();
    chk("f_ifgnt", 32'(bus.if_gnt), 1);
    chk("f_lsgnt", 32'(bus.ls_gnt), 0);
    tick();
    bus.if_req = 0;
    mid();
    chk("f_men1", 32'(bus.mem_enable), 1);
    chk("f_maddr", 32'(bus.mem_addr), 32'h0040);
    chk("f_mwr", 32'(bus.mem_wr), 0);
    chk("f_busy", 32'(bus.busy), 1);
    tick();
    mid();
    chk("f_men2", 32'(bus.mem_enable), 1);
    tick();
    mid();
    chk("f_rv", 32'(bus.if_rvalid), 1);
    chk("f_rd", 32'(bus.if_rdata), 32'hBEEF);
    chk("f_men3", 32'(bus.mem_enable), 0);
    chk("f_lsrv", 32'(bus.ls_rvalid), 0);
    tick();
    mid();
    chk("f_rv_end", 32'(bus.if_rvalid), 0);
    chk("f_idle", 32'(bus.busy), 0);

    // store
    tick();
    bus.ls_req = 1;
    bus.ls_wr = 1;
    bus.ls_addr = 16'h0100;
    bus.ls_wdata = 16'h1234;
    mid();
    chk("s_gnt", 32'(bus.ls_gnt), 1);
    tick();
    bus.ls_req = 0;
    mid();
    chk("s_mwr1", 32'(bus.mem_wr), 1);
    chk("s_maddr", 32'(bus.mem_addr), 32'h0100);
    chk("s_mdin", 32'(bus.mem_data_in), 32'h1234);
    tick();
    mid();
    chk("s_mwr2", 32'(bus.mem_wr), 1);
    tick();
    mid();
    chk("s_rv", 32'(bus.ls_rvalid), 1);
    chk("s_rd", 32'(bus.ls_rdata), 0);
    chk("s_err", 32'(bus.ls_err), 0);
    chk("s_mwr3", 32'(bus.mem_wr), 0);
    bus.ls_wr = 0;
    tick();

    // starvation: both held; {if_gnt, ls_gnt}
    exp_ord[0] = 2'b01; exp_ord[1] = 2'b01;
    exp_ord[2] = 2'b01; exp_ord[3] = 2'b01;
    exp_ord[4] = 2'b10; exp_ord[5] = 2'b01;
    exp_ord[6] = 2'b01; exp_ord[7] = 2'b01;
    exp_ord[8] = 2'b01; exp_ord[9] = 2'b10;
    bus.if_req = 1;
    bus.ls_req = 1;
    bus.if_addr = 16'h0010;
    bus.ls_addr = 16'h0020;
    ng = 0;
    cyc = 0;
    mid();
    while (ng < 10 && cyc < 100) begin
      if (bus.if_gnt || bus.ls_gnt) begin
        chk($sformatf("ord%0d", ng), 32'({bus.if_gnt, bus.ls_gnt}),
            32'(exp_ord[ng]));
        ng++;
      end
      if (ng < 10) begin
        tick();
        mid();
        cyc++;
      end
    end
    chk("ord_count", 32'(ng), 10);
    tick();
    bus.if_req = 0;
    bus.ls_req = 0;
    mid();
    drain();

    // load with error, then fetch with mem_err still high
    tick();
    bus.ls_req = 1;
    bus.ls_addr = 16'h0200;
    bus.mem_err = 1;
    bus.mem_data_out = 16'h5A5A;
    mid();
    chk("e_gnt", 32'(bus.ls_gnt), 1);
    tick();
    bus.ls_req = 0;
    tick();
    tick();
    mid();
    chk("e_rv", 32'(bus.ls_rvalid), 1);
    chk("e_err", 32'(bus.ls_err), 1);
    chk("e_rd", 32'(bus.ls_rdata), 32'h5A5A);
    tick();
    bus.if_req = 1;
    bus.if_addr = 16'h0044;
    mid();
    chk("e_ifgnt", 32'(bus.if_gnt), 1);
    tick();
    bus.if_req = 0;
    tick();
    tick();
    mid();
    chk("e_ifrv", 32'(bus.if_rvalid), 1);
    chk("e_iferr", 32'(bus.ls_err), 0);
    chk("e_lsrv", 32'(bus.ls_rvalid), 0);
    tick();
    bus.mem_err = 0;

    // reset in the middle of a load
    tick();
    bus.ls_req = 1;
    bus.ls_addr = 16'h0300;
    mid();
    chk("r_gnt", 32'(bus.ls_gnt), 1);
    tick();
    bus.ls_req = 0;
    mid();
    chk("r_men", 32'(bus.mem_enable), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rmid");
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      mid();
      if (bus.ls_rvalid || bus.if_rvalid) seen = 1;
      tick();
    end
    chk("r_no_rv", 32'(seen), 0);
    bus.ls_req = 1;
    bus.ls_addr = 16'h0304;
    mid();
    chk("r_regnt", 32'(bus.ls_gnt), 1);
    tick();
    bus.ls_req = 0;
    mid();
    drain();

    // back-to-back loads
    tick();
    bus.ls_req = 1;
    bus.ls_addr = 16'h0400;
    mid();
    chk("b_gnt1", 32'(bus.ls_gnt), 1);
    cyc = 0;
    do begin
      tick();
      mid();
      cyc++;
    end while (!bus.ls_gnt && cyc < 20);
    chk("b_gap", 32'(cyc), 4);
    tick();
    bus.ls_req = 0;
    mid();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
